cve2_rvfi_trace_buffer: RTL and testbench
=========================================

CVE2_RVFI_TRACE_BUFFER -- requirements
Module: cve2_rvfi_trace_buffer

Interface
REQ-001 SHALL have parameter Depth, default 16, number of trace records held (power of two, >= 2).
REQ-002 SHALL have parameter TrigCount, default 8, number of records captured after a trigger (1..65535).
REQ-003 SHALL have ports clk_i (in, 1, clock) and rst_ni (in, 1, reset), in that order: one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port rvfi_valid (in, 1), which marks one retired instruction this cycle.
REQ-005 SHALL have ports rvfi_pc_rdata, rvfi_insn and rvfi_rd_wdata (in, 32 each); rvfi_rd_addr (in, 5); rvfi_trap and rvfi_intr (in, 1 each).
REQ-006 SHALL have port mode_i (in, 2), encoded as trace_mode_e: OFF=0, WRAP=1, STOP=2, TRIG=3.
REQ-007 SHALL have port trig_pc_i (in, 32), the trigger PC.
REQ-008 SHALL have port arm_i (in, 1), a single-cycle pulse that arms the trigger.
REQ-009 SHALL have ports rec_valid_o (out, 1), rec_ready_i (in, 1) and rec_o (out, 103, trace_rec_t), forming the output record stream.
REQ-010 SHALL have port level_o (out, $clog2(Depth)+1), the current occupancy.
REQ-011 SHALL have port drop_cnt_o (out, 16), a saturating count of lost records.
REQ-012 SHALL have port trig_state_o (out, 2, trig_state_e), the trigger state.

Function
REQ-013 trace_rec_t SHALL be packed MSB to LSB as {pc 32, insn 32, rd_addr 5, rd_wdata 32, trap 1, intr 1}.
REQ-014 A record SHALL be offered for capture when rvfi_valid=1 and the mode permits (REQ-017..019); the record is written at the clock edge.
REQ-015 Output SHALL be first-word fall-through: rec_o is the oldest entry whenever rec_valid_o=1; a pop happens when rec_valid_o && rec_ready_i.
REQ-016 Latency SHALL be exactly one cycle: a capture at edge N gives rec_valid_o=1 after edge N when the buffer was empty; there is no combinational bypass.
REQ-017 In OFF mode there SHALL be no capture; the buffer keeps draining normally.
REQ-018 In WRAP mode, a capture with the buffer full and no pop in the same cycle SHALL overwrite the oldest entry: read pointer advances, level unchanged, drop_cnt_o +1.
REQ-019 In STOP mode, a capture with the buffer full and no pop in the same cycle SHALL be discarded, with drop_cnt_o +1.
REQ-020 When full and a pop and a capture occur in the same cycle, both SHALL be accepted, the level SHALL be unchanged and nothing is dropped.
REQ-021 When empty and rvfi_valid=1 with a capture, there SHALL be no pop that cycle; empty and full are never ambiguous (pointers are one bit wider than the address).
REQ-022 The trigger FSM SHALL have states IDLE=0, ARMED=1, CAPT=2, DONE=3; it is active only in TRIG mode and otherwise is held in IDLE.
REQ-023 IDLE SHALL go to ARMED on arm_i; arm_i in any other state SHALL restart the FSM to ARMED.
REQ-024 ARMED SHALL go to CAPT on rvfi_valid && rvfi_pc_rdata==trig_pc_i; the matching record is captured and counts as the first.
REQ-025 CAPT SHALL capture each rvfi_valid and go to DONE once TrigCount records are offered; records lost while full count as offered and count as drops (STOP semantics).
REQ-026 DONE SHALL hold, with no capture, until arm_i or a mode change.
REQ-027 Any change of mode_i SHALL return the FSM to IDLE next cycle without flushing the buffer.
REQ-028 drop_cnt_o SHALL saturate at 16'hFFFF and never wrap.
REQ-029 level_o SHALL equal entries written minus entries read, in the range 0..Depth.

Reset
REQ-030 On rst_ni=0, asynchronously: pointers 0, level_o 0, rec_valid_o 0, drop_cnt_o 0, trig_state_o IDLE; storage is not reset.
REQ-031 Reset asserted mid-capture or mid-drain SHALL discard all content; rec_o is don't-care while rec_valid_o=0.

Structure
REQ-032 trace_rec_t, trace_mode_e and trig_state_e SHALL be in cve2_pkg.
REQ-033 Storage and pointers SHALL sit in one sub-module, cve2_trace_fifo (parameter Depth, overwrite-oldest input); the FSM and counters SHALL stay in the top.

Verification
REQ-034 Test WRAP, Depth=4, rec_ready_i=0, 6 retirements at pc 0x100..0x114 -> level_o=4, drop_cnt_o=2; draining yields pc 0x108, 0x10C, 0x110, 0x114.
REQ-035 Test STOP, Depth=4, same stimulus -> drop_cnt_o=2; draining yields pc 0x100..0x10C.
REQ-036 Test full buffer, simultaneous pop and rvfi_valid -> level_o stays 4, drop_cnt_o unchanged, new record is last out.
REQ-037 Test TRIG with trig_pc_i=0x200, TrigCount=3, arm pulse, retirements 0x1F8..0x210 -> exactly 0x200, 0x204, 0x208 are captured; trig_state_o=DONE.
REQ-038 Test 70000 drops in STOP -> drop_cnt_o=16'hFFFF.
REQ-039 Test rst_ni low with 3 entries buffered -> immediately rec_valid_o=0, level_o=0, trig_state_o=IDLE.

Source files
------------

// File: rtl/cve2_pkg.sv
// rtl/cve2_pkg.sv - shared types for the RVFI trace buffer
package cve2_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'd0,
    MODE_WRAP = 2'd1,
    MODE_STOP = 2'd2,
    MODE_TRIG = 2'd3
  } trace_mode_e;

  typedef enum logic [1:0] {
    TRIG_IDLE  = 2'd0,
    TRIG_ARMED = 2'd1,
    TRIG_CAPT  = 2'd2,
    TRIG_DONE  = 2'd3
  } trig_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic        trap;
    logic        intr;
  } trace_rec_t;

endpackage

// File: rtl/cve2_trace_fifo.sv
// rtl/cve2_trace_fifo.sv - first-word fall-through record store with overwrite-oldest option
module cve2_trace_fifo
  import cve2_pkg::*;
#(
  parameter int Depth = 16,
  localparam int AW = $clog2(Depth)
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       i_wr_en,
  input  logic       i_overwrite,
  input  trace_rec_t i_wdata,
  input  logic       i_rd_en,
  output trace_rec_t o_rdata,
  output logic       o_valid,
  output logic [AW:0] o_level,
  output logic       o_drop
);

  localparam logic [AW:0] FullLvl = (AW+1)'(Depth);

  trace_rec_t  r_mem [Depth];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;

  logic [AW:0] w_level;
  logic        w_full;
  logic        w_empty;
  logic        w_pop;
  logic        w_push;
  logic        w_evict;

  assign w_level = r_wptr - r_rptr;
  assign w_full  = (w_level == FullLvl);
  assign w_empty = (r_wptr == r_rptr);
  assign w_pop   = i_rd_en && !w_empty;
  // A full buffer still accepts a write when the same cycle frees a slot.
  assign w_push  = i_wr_en && (!w_full || w_pop || i_overwrite);
  assign w_evict = i_wr_en && w_full && !w_pop && i_overwrite;
  assign o_drop  = i_wr_en && w_full && !w_pop;

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop || w_evict) r_rptr <= r_rptr + 1'b1;
    end
  end

  assign o_rdata = r_mem[r_rptr[AW-1:0]];
  assign o_valid = !w_empty;
  assign o_level = w_level;

endmodule

// File: rtl/cve2_rvfi_trace_buffer.sv
// rtl/cve2_rvfi_trace_buffer.sv - RVFI retirement trace buffer with wrap/stop/trigger capture
module cve2_rvfi_trace_buffer
  import cve2_pkg::*;
#(
  parameter int Depth     = 16,
  parameter int TrigCount = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   rvfi_valid,
  input  logic [31:0]            rvfi_pc_rdata,
  input  logic [31:0]            rvfi_insn,
  input  logic [31:0]            rvfi_rd_wdata,
  input  logic [4:0]             rvfi_rd_addr,
  input  logic                   rvfi_trap,
  input  logic                   rvfi_intr,
  input  logic [1:0]             mode_i,
  input  logic [31:0]            trig_pc_i,
  input  logic                   arm_i,
  output logic                   rec_valid_o,
  input  logic                   rec_ready_i,
  output trace_rec_t             rec_o,
  output logic [$clog2(Depth):0] level_o,
  output logic [15:0]            drop_cnt_o,
  output trig_state_e            trig_state_o
);

  localparam logic [15:0] TrigLast = 16'(TrigCount - 1);

  trace_mode_e r_mode_q;
  trig_state_e r_state;
  logic [15:0] r_cnt;
  logic [15:0] r_drop;

  trace_mode_e w_mode;
  trace_rec_t  w_rec;
  logic        w_trig_hit;
  logic        w_trig_active;
  logic        w_offer;
  logic        w_overwrite;
  logic        w_drop;

  assign w_mode     = trace_mode_e'(mode_i);
  assign w_trig_hit = rvfi_valid && (rvfi_pc_rdata == trig_pc_i);
  // An arm pulse or a mode switch restarts the FSM, so it captures nothing that cycle.
  assign w_trig_active = (w_mode == MODE_TRIG) && (w_mode == r_mode_q) && !arm_i;

  assign w_rec = '{pc: rvfi_pc_rdata, insn: rvfi_insn, rd_addr: rvfi_rd_addr,
                   rd_wdata: rvfi_rd_wdata, trap: rvfi_trap, intr: rvfi_intr};

  always_comb begin
    w_offer     = 1'b0;
    w_overwrite = 1'b0;
    case (w_mode)
      MODE_WRAP: begin
        w_offer     = rvfi_valid;
        w_overwrite = 1'b1;
      end
      MODE_STOP: w_offer = rvfi_valid;
      MODE_TRIG: begin
        if (w_trig_active) begin
          if (r_state == TRIG_ARMED) w_offer = w_trig_hit;
          else if (r_state == TRIG_CAPT) w_offer = rvfi_valid;
        end
      end
      default: w_offer = 1'b0;
    endcase
  end

  cve2_trace_fifo #(.Depth(Depth)) u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .i_wr_en    (w_offer),
    .i_overwrite(w_overwrite),
    .i_wdata    (w_rec),
    .i_rd_en    (rec_ready_i),
    .o_rdata    (rec_o),
    .o_valid    (rec_valid_o),
    .o_level    (level_o),
    .o_drop     (w_drop)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mode_q <= MODE_OFF;
      r_state  <= TRIG_IDLE;
      r_cnt    <= '0;
      r_drop   <= '0;
    end else begin
      r_mode_q <= w_mode;
      if (w_drop && (r_drop != 16'hFFFF)) r_drop <= r_drop + 16'd1;
      if ((w_mode != MODE_TRIG) || (w_mode != r_mode_q)) begin
        r_state <= TRIG_IDLE;
      end else if (arm_i) begin
        r_state <= TRIG_ARMED;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          TRIG_ARMED: begin
            if (w_trig_hit) begin
              r_cnt   <= 16'd1;
              r_state <= (TrigLast == 16'd0) ? TRIG_DONE : TRIG_CAPT;
            end
          end
          TRIG_CAPT: begin
            if (rvfi_valid) begin
              r_cnt <= r_cnt + 16'd1;
              if (r_cnt == TrigLast) r_state <= TRIG_DONE;
            end
          end
          default: r_state <= r_state;
        endcase
      end
    end
  end

  assign drop_cnt_o   = r_drop;
  assign trig_state_o = r_state;

endmodule

// File: tb/tb_cve2_rvfi_trace_buffer.sv
// tb/tb_cve2_rvfi_trace_buffer.sv - self-checking bench for cve2_rvfi_trace_buffer
module tb_cve2_rvfi_trace_buffer;
  import cve2_pkg::*;

  localparam int DEPTH = 4;
  localparam int TRIGN = 3;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        rvfi_valid = 1'b0;
  logic [31:0] rvfi_pc_rdata = '0;
  logic [31:0] rvfi_insn = '0;
  logic [31:0] rvfi_rd_wdata = '0;
  logic [4:0]  rvfi_rd_addr = '0;
  logic        rvfi_trap = 1'b0;
  logic        rvfi_intr = 1'b0;
  logic [1:0]  mode_i = 2'd0;
  logic [31:0] trig_pc_i = '0;
  logic        arm_i = 1'b0;
  logic        rec_valid_o;
  logic        rec_ready_i = 1'b0;
  trace_rec_t  rec_o;
  logic [2:0]  level_o;
  logic [15:0] drop_cnt_o;
  trig_state_e trig_state_o;

  int n_checks = 0;
  int n_errors = 0;

  trace_rec_t  sb[$];
  logic [1:0]  m_mode;

  always #5 clk = ~clk;

  cve2_rvfi_trace_buffer #(.Depth(DEPTH), .TrigCount(TRIGN)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .rvfi_valid   (rvfi_valid),
    .rvfi_pc_rdata(rvfi_pc_rdata),
    .rvfi_insn    (rvfi_insn),
    .rvfi_rd_wdata(rvfi_rd_wdata),
    .rvfi_rd_addr (rvfi_rd_addr),
    .rvfi_trap    (rvfi_trap),
    .rvfi_intr    (rvfi_intr),
    .mode_i       (mode_i),
    .trig_pc_i    (trig_pc_i),
    .arm_i        (arm_i),
    .rec_valid_o  (rec_valid_o),
    .rec_ready_i  (rec_ready_i),
    .rec_o        (rec_o),
    .level_o      (level_o),
    .drop_cnt_o   (drop_cnt_o),
    .trig_state_o (trig_state_o)
  );

  function automatic trace_rec_t mk_rec(input logic [31:0] pc);
    trace_rec_t r;
    r.pc       = pc;
    r.insn     = pc ^ 32'hA5A5_A5A5;
    r.rd_addr  = pc[6:2];
    r.rd_wdata = ~pc;
    r.trap     = pc[2];
    r.intr     = pc[3];
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, update the model, pop-check, advance to #1 after the edge.
  task automatic step(input logic v, input logic [31:0] pc, input logic rdy, input logic cap);
    trace_rec_t r;
    r = mk_rec(pc);
    rvfi_valid    = v;
    rvfi_pc_rdata = r.pc;
    rvfi_insn     = r.insn;
    rvfi_rd_addr  = r.rd_addr;
    rvfi_rd_wdata = r.rd_wdata;
    rvfi_trap     = r.trap;
    rvfi_intr     = r.intr;
    rec_ready_i   = rdy;
    chk("rec_valid", {127'd0, rec_valid_o}, {127'd0, (sb.size() != 0)});
    if (rdy && sb.size() != 0) begin
      chk("rec_data", {25'd0, rec_o}, {25'd0, sb[0]});
      void'(sb.pop_front());
    end
    if (cap) begin
      if (sb.size() < DEPTH) sb.push_back(r);
      else if (m_mode == 2'd1) begin
        void'(sb.pop_front());
        sb.push_back(r);
      end
    end
    @(posedge clk);
    #1;
    rvfi_valid  = 1'b0;
    rec_ready_i = 1'b0;
    arm_i       = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    #3;
    rst_ni = 1'b1;
    sb.delete();
  endtask

  task automatic set_mode(input logic [1:0] m);
    mode_i = m;
    m_mode = m;
    step(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 16 && sb.size() != 0; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("drain_done", 128'(sb.size()), 128'd0);
    chk("drain_level", 128'(level_o), 128'd0);
    chk("drain_valid", {127'd0, rec_valid_o}, 128'd0);
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [2:0]  exp_level;
    logic [15:0] exp_drop;
  } scen_t;

  typedef struct {
    logic [31:0] pc;
    logic        exp_cap;
    trig_state_e exp_state;
  } trig_vec_t;

  scen_t     scen[3];
  trig_vec_t tvec[7];

  initial begin
    scen[0] = '{2'd0, 3'd0, 16'd0};
    scen[1] = '{2'd1, 3'd4, 16'd2};
    scen[2] = '{2'd2, 3'd4, 16'd2};
    tvec[0] = '{32'h1F8, 1'b0, TRIG_ARMED};
    tvec[1] = '{32'h1FC, 1'b0, TRIG_ARMED};
    tvec[2] = '{32'h200, 1'b1, TRIG_CAPT};
    tvec[3] = '{32'h204, 1'b1, TRIG_CAPT};
    tvec[4] = '{32'h208, 1'b1, TRIG_DONE};
    tvec[5] = '{32'h20C, 1'b0, TRIG_DONE};
    tvec[6] = '{32'h210, 1'b0, TRIG_DONE};
    m_mode = 2'd0;

    @(posedge clk);
    #1;
    chk("reset_valid", {127'd0, rec_valid_o}, 128'd0);
    chk("reset_level", 128'(level_o), 128'd0);
    chk("reset_drop", 128'(drop_cnt_o), 128'd0);
    chk("reset_trig", 128'(trig_state_o), 128'(TRIG_IDLE));
    rst_ni = 1'b1;

    // OFF / WRAP / STOP: six retirements into a 4-deep buffer with no reader
    foreach (scen[s]) begin
      do_reset();
      set_mode(scen[s].mode);
      for (int i = 0; i < 6; i++) step(1'b1, 32'h100 + 32'(4 * i), 1'b0, scen[s].mode != 2'd0);
      chk("scen_level", 128'(level_o), 128'(scen[s].exp_level));
      chk("scen_drop", 128'(drop_cnt_o), 128'(scen[s].exp_drop));
      drain();
    end

    // full buffer, pop and capture in the same cycle
    do_reset();
    set_mode(2'd2);
    for (int i = 0; i < 4; i++) step(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b1);
    step(1'b1, 32'h300, 1'b1, 1'b1);
    chk("simul_level", 128'(level_o), 128'd4);
    chk("simul_drop", 128'(drop_cnt_o), 128'd0);
    drain();

    // trigger capture window
    do_reset();
    trig_pc_i = 32'h200;
    set_mode(2'd3);
    chk("trig_idle", 128'(trig_state_o), 128'(TRIG_IDLE));
    arm_i = 1'b1;
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("trig_armed", 128'(trig_state_o), 128'(TRIG_ARMED));
    foreach (tvec[i]) begin
      step(1'b1, tvec[i].pc, 1'b0, tvec[i].exp_cap);
      chk("trig_state", 128'(trig_state_o), 128'(tvec[i].exp_state));
    end
    chk("trig_level", 128'(level_o), 128'd3);
    drain();

    // re-arm, fill three entries, then reset mid-cycle
    arm_i = 1'b1;
    step(1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h200 + 32'(4 * i), 1'b0, 1'b1);
    chk("pre_rst_level", 128'(level_o), 128'd3);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("rst_valid", {127'd0, rec_valid_o}, 128'd0);
    chk("rst_level", 128'(level_o), 128'd0);
    chk("rst_trig", 128'(trig_state_o), 128'(TRIG_IDLE));
    #1;
    rst_ni = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;

    // drop counter saturation
    do_reset();
    set_mode(2'd2);
    for (int i = 0; i < 4; i++) step(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b1);
    rvfi_valid = 1'b1;
    rvfi_pc_rdata = 32'h400;
    repeat (70000) @(posedge clk);
    #1;
    rvfi_valid = 1'b0;
    chk("sat_drop", 128'(drop_cnt_o), 128'h0FFFF);
    chk("sat_level", 128'(level_o), 128'd4);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
